// File: rtl/cpu_pkg.sv
// Shared pipeline types for the memory stage: load/store op codes and datapath widths.
// Also holds the small decode helper used by the data-memory interface FSM.
package cpu_pkg;

    localparam int DW = 10;
    localparam int RW = 3;

    typedef enum logic [1:0] {
        LDST_NONE  = 2'b00,
        LDST_LOAD  = 2'b01,
        LDST_STORE = 2'b10,
        LDST_RSVD  = 2'b11
    } ldst_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } mem_state_e;

    function automatic logic is_mem_op(input logic [1:0] code);
        return (code == LDST_LOAD) || (code == LDST_STORE);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory handshake: IDLE/WAIT FSM, request latches and optional access timeout.
// The timeout counter and mem_err pulse exist only when MEM_TIMEOUT_EN is defined.
//   state  | meaning
//   S_IDLE | accepting a new op; a request is driven straight from the EX/MEM inputs
//   S_WAIT | request outstanding; memory-side outputs come from the latched copy
module dmem_if
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    ldst_en,
    input  logic          wr_en,
    input  logic [DW-1:0] alu_out,
    input  logic [RW-1:0] wr_reg,
    input  logic [DW-1:0] t1,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          stall,
    output logic          done,
    output logic          done_wr_en,
    output logic [RW-1:0] done_wr_reg,
    output logic          pass_thru,
    output logic          abort,
    output logic          mem_err
);

    mem_state_e    state_q, state_d;
    logic [DW-1:0] lat_addr_q, lat_wdata_q;
    logic          lat_we_q, lat_wr_en_q;
    logic [RW-1:0] lat_wr_reg_q;
    logic          op;
    logic          limit;

    assign op = is_mem_op(ldst_en);

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_err_q;

    assign limit = (state_q == S_WAIT) && (cnt_q == CW'(TIMEOUT_CYC));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            cnt_d = '0;
        end else if (!mem_ack && !limit) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            mem_err_q <= abort;
        end
    end

    assign mem_err = mem_err_q;
`else
    assign limit   = 1'b0;
    assign mem_err = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_we      = lat_we_q;
        mem_addr    = lat_addr_q;
        mem_wdata   = lat_wdata_q;
        done_wr_en  = lat_wr_en_q;
        done_wr_reg = lat_wr_reg_q;
        pass_thru   = 1'b0;
        abort       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op) begin
                    mem_req     = 1'b1;
                    mem_we      = ldst_en[1];
                    mem_addr    = alu_out;
                    mem_wdata   = t1;
                    done_wr_en  = wr_en;
                    done_wr_reg = wr_reg;
                    if (!mem_ack) state_d = S_WAIT;
                end else begin
                    pass_thru = 1'b1;
                end
            end
            S_WAIT: begin
                mem_req = 1'b1;
                // an ack arriving on the limit cycle still completes normally
                if (mem_ack) begin
                    state_d = S_IDLE;
                end else if (limit) begin
                    mem_req = 1'b0;
                    abort   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (rst) begin
            mem_req   = 1'b0;
            pass_thru = 1'b0;
            abort     = 1'b0;
            state_d   = S_IDLE;
        end
    end

    assign stall = mem_req & ~mem_ack;
    assign done  = mem_req & mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            lat_addr_q   <= '0;
            lat_wdata_q  <= '0;
            lat_we_q     <= 1'b0;
            lat_wr_en_q  <= 1'b0;
            lat_wr_reg_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && op) begin
                lat_addr_q   <= alu_out;
                lat_wdata_q  <= t1;
                lat_we_q     <= ldst_en[1];
                lat_wr_en_q  <= wr_en;
                lat_wr_reg_q <= wr_reg;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: drives the data-memory port through dmem_if and owns the write-back registers.
// Build with MEM_TIMEOUT_EN defined to abort accesses that stay unacknowledged for TIMEOUT_CYC cycles.
module mem_stage
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    ldst_en,
    input  logic          wr_en,
    input  logic [DW-1:0] alu_out,
    input  logic [RW-1:0] wr_reg,
    input  logic [DW-1:0] t1,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata,
    output logic          wb_wr_en,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_reg,
    output logic          mem_err
);

    logic          done, done_wr_en, pass_thru, abort;
    logic [RW-1:0] done_wr_reg;
    logic          wb_wr_en_q;
    logic [DW-1:0] wb_data_q;
    logic [RW-1:0] wb_reg_q;

    dmem_if #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_dmem_if (
        .clk         (clk),
        .rst         (rst),
        .ldst_en     (ldst_en),
        .wr_en       (wr_en),
        .alu_out     (alu_out),
        .wr_reg      (wr_reg),
        .t1          (t1),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .stall       (stall),
        .done        (done),
        .done_wr_en  (done_wr_en),
        .done_wr_reg (done_wr_reg),
        .pass_thru   (pass_thru),
        .abort       (abort),
        .mem_err     (mem_err)
    );

    // stalls, stores and aborted accesses all retire as bubbles; data/index hold
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wr_en_q <= 1'b0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
        end else if (stall || abort) begin
            wb_wr_en_q <= 1'b0;
        end else if (done) begin
            if (mem_we) begin
                wb_wr_en_q <= 1'b0;
            end else begin
                wb_wr_en_q <= done_wr_en;
                wb_data_q  <= mem_rdata;
                wb_reg_q   <= done_wr_reg;
            end
        end else if (pass_thru) begin
            wb_wr_en_q <= wr_en;
            wb_data_q  <= alu_out;
            wb_reg_q   <= wr_reg;
        end
    end

    assign wb_wr_en = wb_wr_en_q;
    assign wb_data  = wb_data_q;
    assign wb_reg   = wb_reg_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: single-cycle vector table plus stall, reset and timeout sequences.
module tb_mem_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ldst_en;
    logic       wr_en;
    logic [9:0] alu_out;
    logic [2:0] wr_reg;
    logic [9:0] t1;
    logic       stall, mem_req, mem_we;
    logic [9:0] mem_addr, mem_wdata;
    logic       mem_ack;
    logic [9:0] mem_rdata;
    logic       wb_wr_en;
    logic [9:0] wb_data;
    logic [2:0] wb_reg;
    logic       mem_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYC(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .ldst_en   (ldst_en),
        .wr_en     (wr_en),
        .alu_out   (alu_out),
        .wr_reg    (wr_reg),
        .t1        (t1),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_wr_en  (wb_wr_en),
        .wb_data   (wb_data),
        .wb_reg    (wb_reg),
        .mem_err   (mem_err)
    );

    typedef struct {
        logic [1:0] ldst;
        logic       wen;
        logic [9:0] alu;
        logic [2:0] wreg;
        logic [9:0] wdat;
        logic       ack;
        logic [9:0] rdat;
        logic       e_stall;
        logic       e_req;
        logic       e_we;
        logic [9:0] e_addr;
        logic [9:0] e_wdata;
        logic       e_wb_en;
        logic [9:0] e_wb_data;
        logic [2:0] e_wb_reg;
    } vec_t;

    vec_t vecs[6];

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk3(input string nm, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk10(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] l, input logic we, input logic [9:0] a,
                         input logic [2:0] r, input logic [9:0] d, input logic ack,
                         input logic [9:0] rd);
        ldst_en   = l;
        wr_en     = we;
        alu_out   = a;
        wr_reg    = r;
        t1        = d;
        mem_ack   = ack;
        mem_rdata = rd;
    endtask

    task automatic chk_mem(input string tag, input logic e_stall, input logic e_req,
                           input logic e_we, input logic [9:0] e_addr, input logic [9:0] e_wdata);
        chk1({tag, ".stall"}, stall, e_stall);
        chk1({tag, ".mem_req"}, mem_req, e_req);
        if (e_req) begin
            chk1({tag, ".mem_we"}, mem_we, e_we);
            chk10({tag, ".mem_addr"}, mem_addr, e_addr);
            chk10({tag, ".mem_wdata"}, mem_wdata, e_wdata);
        end
    endtask

    task automatic chk_wb(input string tag, input logic e_en, input logic [9:0] e_data,
                          input logic [2:0] e_reg, input logic e_err);
        chk1({tag, ".wb_wr_en"}, wb_wr_en, e_en);
        chk10({tag, ".wb_data"}, wb_data, e_data);
        chk3({tag, ".wb_reg"}, wb_reg, e_reg);
        chk1({tag, ".mem_err"}, mem_err, e_err);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'b00, 1'b1, 10'h155, 3'd3, 10'h000, 1'b0, 10'h000,
                    1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h155, 3'd3};
        vecs[1] = '{2'b01, 1'b1, 10'h020, 3'd5, 10'h000, 1'b1, 10'h3FF,
                    1'b0, 1'b1, 1'b0, 10'h020, 10'h000, 1'b1, 10'h3FF, 3'd5};
        vecs[2] = '{2'b10, 1'b1, 10'h010, 3'd2, 10'h0AA, 1'b1, 10'h000,
                    1'b0, 1'b1, 1'b1, 10'h010, 10'h0AA, 1'b0, 10'h3FF, 3'd5};
        vecs[3] = '{2'b11, 1'b0, 10'h2A5, 3'd7, 10'h000, 1'b1, 10'h111,
                    1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b0, 10'h2A5, 3'd7};
        vecs[4] = '{2'b00, 1'b1, 10'h001, 3'd1, 10'h000, 1'b1, 10'h000,
                    1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 1'b1, 10'h001, 3'd1};
        vecs[5] = '{2'b01, 1'b0, 10'h3FE, 3'd6, 10'h0C3, 1'b1, 10'h0F0,
                    1'b0, 1'b1, 1'b0, 10'h3FE, 10'h0C3, 1'b0, 10'h0F0, 3'd6};

        // reset: outputs forced low even with a load presented
        rst = 1'b1;
        drive(2'b01, 1'b1, 10'h123, 3'd4, 10'h045, 1'b0, 10'h000);
        repeat (2) @(posedge clk);
        #1;
        chk_mem("rst", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        chk_wb("rst", 1'b0, 10'h000, 3'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 10'h000, 3'd0, 10'h000, 1'b0, 10'h000);
        @(posedge clk);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive(vecs[i].ldst, vecs[i].wen, vecs[i].alu, vecs[i].wreg, vecs[i].wdat,
                  vecs[i].ack, vecs[i].rdat);
            #1;
            chk_mem($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_req, vecs[i].e_we,
                    vecs[i].e_addr, vecs[i].e_wdata);
            @(posedge clk);
            #1;
            chk_wb($sformatf("vec%0d", i), vecs[i].e_wb_en, vecs[i].e_wb_data,
                   vecs[i].e_wb_reg, 1'b0);
        end

        // store acked after three stalled cycles; upstream inputs wander to prove latching
        @(negedge clk);
        drive(2'b00, 1'b1, 10'h077, 3'd2, 10'h000, 1'b0, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("st_pre", 1'b1, 10'h077, 3'd2, 1'b0);
        @(negedge clk);
        drive(2'b10, 1'b1, 10'h010, 3'd3, 10'h0AA, 1'b0, 10'h000);
        #1;
        chk_mem("st_c0", 1'b1, 1'b1, 1'b1, 10'h010, 10'h0AA);
        @(posedge clk);
        #1;
        chk_wb("st_c0", 1'b0, 10'h077, 3'd2, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            drive(2'b01, 1'b0, 10'h3C0 + 10'(k), 3'd6, 10'h155, 1'b0, 10'h000);
            #1;
            chk_mem($sformatf("st_w%0d", k), 1'b1, 1'b1, 1'b1, 10'h010, 10'h0AA);
            @(posedge clk);
            #1;
            chk_wb($sformatf("st_w%0d", k), 1'b0, 10'h077, 3'd2, 1'b0);
        end
        @(negedge clk);
        drive(2'b01, 1'b0, 10'h3C5, 3'd6, 10'h155, 1'b1, 10'h2AA);
        #1;
        chk_mem("st_ack", 1'b0, 1'b1, 1'b1, 10'h010, 10'h0AA);
        @(posedge clk);
        #1;
        chk_wb("st_ack", 1'b0, 10'h077, 3'd2, 1'b0);
        @(negedge clk);
        drive(2'b00, 1'b0, 10'h100, 3'd1, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("st_idle", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("st_idle", 1'b0, 10'h100, 3'd1, 1'b0);

        // load completing from WAIT must use the latched destination
        @(negedge clk);
        drive(2'b01, 1'b1, 10'h0C3, 3'd4, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("ldw_c0", 1'b1, 1'b1, 1'b0, 10'h0C3, 10'h000);
        @(negedge clk);
        drive(2'b10, 1'b0, 10'h0AB, 3'd7, 10'h3FF, 1'b0, 10'h000);
        #1;
        chk_mem("ldw_w0", 1'b1, 1'b1, 1'b0, 10'h0C3, 10'h000);
        @(negedge clk);
        drive(2'b10, 1'b0, 10'h0AB, 3'd7, 10'h3FF, 1'b1, 10'h2B7);
        #1;
        chk_mem("ldw_ack", 1'b0, 1'b1, 1'b0, 10'h0C3, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("ldw_ack", 1'b1, 10'h2B7, 3'd4, 1'b0);

        // reset asserted in the second WAIT cycle drops the access
        @(negedge clk);
        drive(2'b01, 1'b1, 10'h055, 3'd5, 10'h000, 1'b0, 10'h000);
        @(negedge clk);
        #1;
        chk_mem("rw_w0", 1'b1, 1'b1, 1'b0, 10'h055, 10'h000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_mem("rw_rst", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 10'h000, 3'd0, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("rw_after", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        chk_wb("rw_after", 1'b0, 10'h000, 3'd0, 1'b0);

        // load never acknowledged
        @(negedge clk);
        drive(2'b00, 1'b1, 10'h2C2, 3'd3, 10'h000, 1'b0, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("to_pre", 1'b1, 10'h2C2, 3'd3, 1'b0);
        @(negedge clk);
        drive(2'b01, 1'b1, 10'h1E0, 3'd5, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("to_c0", 1'b1, 1'b1, 1'b0, 10'h1E0, 10'h000);
`ifdef MEM_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            #1;
            chk_mem($sformatf("to_w%0d", k), 1'b1, 1'b1, 1'b0, 10'h1E0, 10'h000);
            chk1($sformatf("to_w%0d.mem_err", k), mem_err, 1'b0);
        end
        @(negedge clk);
        #1;
        chk_mem("to_limit", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("to_err", 1'b0, 10'h2C2, 3'd3, 1'b1);
        @(negedge clk);
        drive(2'b00, 1'b0, 10'h00F, 3'd0, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("to_idle", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("to_idle", 1'b0, 10'h00F, 3'd0, 1'b0);

        // ack on the limit cycle wins over the timeout
        @(negedge clk);
        drive(2'b01, 1'b1, 10'h1E1, 3'd5, 10'h000, 1'b0, 10'h000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
        end
        @(negedge clk);
        drive(2'b01, 1'b1, 10'h1E1, 3'd5, 10'h000, 1'b1, 10'h19A);
        #1;
        chk_mem("tl_ack", 1'b0, 1'b1, 1'b0, 10'h1E1, 10'h000);
        @(posedge clk);
        #1;
        chk_wb("tl_ack", 1'b1, 10'h19A, 3'd5, 1'b0);
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            #1;
            chk_mem($sformatf("nt_w%0d", k), 1'b1, 1'b1, 1'b0, 10'h1E0, 10'h000);
            chk1($sformatf("nt_w%0d.mem_err", k), mem_err, 1'b0);
            chk1($sformatf("nt_w%0d.wb_wr_en", k), wb_wr_en, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(2'b00, 1'b0, 10'h00F, 3'd0, 10'h000, 1'b0, 10'h000);
        #1;
        chk_mem("nt_idle", 1'b0, 1'b0, 1'b0, 10'h000, 10'h000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
